// File: rtl/ifft_frame_sequencer.sv
// Frames a subcarrier stream into fixed-size IFFT input blocks with SOP/EOP, fft_pts
// and zero padding, while capping the number of frames in flight inside the IFFT core.
module ifft_frame_sequencer #(
  parameter int MAX_INFLIGHT = 2,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    cfg_points,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          fft_sink_valid,
  input  logic          fft_sink_ready,
  output logic          fft_sink_sop,
  output logic          fft_sink_eop,
  output logic [1:0]    fft_sink_error,
  output logic [DW-1:0] fft_sink_real,
  output logic [DW-1:0] fft_sink_imag,
  output logic [7:0]    fft_pts,
  input  logic          fft_src_valid,
  input  logic          fft_src_ready,
  input  logic          fft_src_eop,
  output logic [15:0]   frame_count,
  output logic          cfg_err,
  output logic          proto_err
);

  typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;

  localparam logic [2:0] MAX_IF = 3'(MAX_INFLIGHT);

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] inflight;
  logic       load_ok;
  logic       cfg_legal;
  logic [7:0] last_idx;
  logic       sop_hs;
  logic       eop_hs;
  logic       src_eop_hs;

  assign load_ok        = !fft_sink_valid || fft_sink_ready;
  assign in_ready       = (state == STREAM) && load_ok;
  assign fft_sink_error = 2'b00;
  assign last_idx       = fft_pts - 8'd1;
  assign cfg_legal      = (cfg_points == 8'd8)  || (cfg_points == 8'd16) ||
                          (cfg_points == 8'd32) || (cfg_points == 8'd64) ||
                          (cfg_points == 8'd128);
  assign sop_hs         = fft_sink_valid && fft_sink_ready && fft_sink_sop;
  assign eop_hs         = fft_sink_valid && fft_sink_ready && fft_sink_eop;
  assign src_eop_hs     = fft_src_valid && fft_src_ready && fft_src_eop;

  // Framing FSM driving the single output register slice; the slice only changes when it can load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      fft_pts        <= 8'd0;
      cfg_err        <= 1'b0;
      fft_sink_valid <= 1'b0;
      fft_sink_sop   <= 1'b0;
      fft_sink_eop   <= 1'b0;
      fft_sink_real  <= '0;
      fft_sink_imag  <= '0;
    end else begin
      if (fft_sink_valid && fft_sink_ready)
        fft_sink_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && (inflight < MAX_IF)) begin
            if (cfg_legal) begin
              fft_pts <= cfg_points;
              cnt     <= 8'd0;
              state   <= STREAM;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (in_valid && in_ready) begin
            fft_sink_valid <= 1'b1;
            fft_sink_real  <= in_real;
            fft_sink_imag  <= in_imag;
            fft_sink_sop   <= (cnt == 8'd0);
            fft_sink_eop   <= (cnt == last_idx);
            cnt            <= cnt + 8'd1;
            if (cnt == last_idx)
              state <= IDLE;
            else if (in_last)
              state <= PAD;
          end
        end
        PAD: begin
          if (load_ok) begin
            fft_sink_valid <= 1'b1;
            fft_sink_real  <= '0;
            fft_sink_imag  <= '0;
            fft_sink_sop   <= 1'b0;
            fft_sink_eop   <= (cnt == last_idx);
            cnt            <= cnt + 8'd1;
            if (cnt == last_idx)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A simultaneous SOP and source EOP cancel out, so no underflow error is raised then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight    <= 3'd0;
      proto_err   <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      case ({sop_hs, src_eop_hs})
        2'b10: inflight <= inflight + 3'd1;
        2'b01: begin
          if (inflight == 3'd0)
            proto_err <= 1'b1;
          else
            inflight <= inflight - 3'd1;
        end
        default: inflight <= inflight;
      endcase
      if (eop_hs)
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ifft_frame_sequencer.sv
// Randomized self-checking bench for ifft_frame_sequencer: a queue of expected IFFT input
// samples is built per frame from the framing rules and compared on every sink handshake.
module tb_ifft_frame_sequencer;

  localparam int DW   = 32;
  localparam int MAXI = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    cfg_points;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  logic          fft_sink_valid;
  logic          fft_sink_ready;
  logic          fft_sink_sop;
  logic          fft_sink_eop;
  logic [1:0]    fft_sink_error;
  logic [DW-1:0] fft_sink_real;
  logic [DW-1:0] fft_sink_imag;
  logic [7:0]    fft_pts;
  logic          fft_src_valid;
  logic          fft_src_ready;
  logic          fft_src_eop;
  logic [15:0]   frame_count;
  logic          cfg_err;
  logic          proto_err;

  ifft_frame_sequencer #(.MAX_INFLIGHT(MAXI), .DW(DW)) dut (
    .clk(clk), .reset(reset), .cfg_points(cfg_points),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_real(in_real), .in_imag(in_imag),
    .fft_sink_valid(fft_sink_valid), .fft_sink_ready(fft_sink_ready),
    .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
    .fft_sink_error(fft_sink_error), .fft_sink_real(fft_sink_real),
    .fft_sink_imag(fft_sink_imag), .fft_pts(fft_pts),
    .fft_src_valid(fft_src_valid), .fft_src_ready(fft_src_ready),
    .fft_src_eop(fft_src_eop), .frame_count(frame_count),
    .cfg_err(cfg_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sop;
    logic          eop;
    logic [7:0]    pts;
  } sample_t;

  sample_t     exp_q[$];
  sample_t     mon_e;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          exp_frames   = 0;
  int          exp_inflight = 0;
  bit          exp_proto    = 1'b0;
  int          sop_count    = 0;
  int          cycle        = 0;
  int          last_eop_cycle = 0;
  int          sop_gap      = 0;
  bit          stall_mode   = 1'b0;
  bit          stalled      = 1'b0;
  logic [65:0] held;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  always @(posedge clk) cycle++;

  // Sink backpressure: always ready, or a coin flip each cycle while stalling is enabled.
  initial begin
    fft_sink_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      fft_sink_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Sink monitor: compares each handshake with the model queue and checks hold while stalled.
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        checkOutput("hold", 128'({fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag}),
                    128'({1'b1, held}));
      if (fft_sink_valid && fft_sink_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected", 128'(fft_sink_valid), 128'(exp_q.size() != 0));
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("sample", 128'({fft_sink_sop, fft_sink_eop, fft_pts, fft_sink_real, fft_sink_imag}),
                      128'({mon_e.sop, mon_e.eop, mon_e.pts, mon_e.re, mon_e.im}));
          if (mon_e.eop) begin
            exp_frames++;
            last_eop_cycle = cycle;
          end
        end
        if (fft_sink_sop) begin
          sop_count++;
          sop_gap = cycle - last_eop_cycle;
        end
      end
      stalled = fft_sink_valid && !fft_sink_ready;
      held    = {fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag};
    end
  end

  task automatic sendSample(input logic [DW-1:0] re, input logic [DW-1:0] im,
                            input bit last, output bit ok);
    int budget = 0;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    in_last  = last;
    while (!ok && budget < 500) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!ok)
      checkOutput("accept_timeout", 128'(ok), 128'(1));
  endtask

  // Offers one frame of len samples for size n and queues the n expected IFFT inputs.
  task automatic applyStimulus(input int n, input int len, input bit use_last);
    logic [DW-1:0] dr [128];
    logic [DW-1:0] di [128];
    sample_t       s;
    bit            ok;
    cfg_points = 8'(n);
    for (int i = 0; i < n; i++) begin
      dr[i] = (i < len) ? DW'($urandom) : '0;
      di[i] = (i < len) ? DW'($urandom) : '0;
      s.re  = dr[i];
      s.im  = di[i];
      s.sop = (i == 0);
      s.eop = (i == n - 1);
      s.pts = 8'(n);
      exp_q.push_back(s);
    end
    for (int i = 0; i < len; i++) begin
      sendSample(dr[i], di[i], use_last && (i == len - 1), ok);
      if (!ok) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDrain();
    int b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(posedge clk);
      b++;
    end
    checkOutput("drain", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic srcEop();
    fft_src_valid = 1'b1;
    fft_src_ready = 1'b1;
    fft_src_eop   = 1'b1;
    if (exp_inflight == 0) exp_proto = 1'b1;
    else exp_inflight--;
    @(posedge clk);
    #1;
    fft_src_valid = 1'b0;
    fft_src_ready = 1'b0;
    fft_src_eop   = 1'b0;
  endtask

  task automatic runFrame(input int n, input int len, input bit use_last);
    applyStimulus(n, len, use_last);
    exp_inflight++;
    waitDrain();
    srcEop();
  endtask

  function automatic logic [127:0] allOutputs();
    return 128'({in_ready, fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_error,
                 fft_sink_real, fft_sink_imag, fft_pts, frame_count, cfg_err, proto_err});
  endfunction

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int pad_ready;
    int bad;
    bit ok;
    int n;
    int len;
    bit use_last;

    reset = 1'b1;
    cfg_points = 8'd0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_real = '0;
    in_imag = '0;
    fft_src_valid = 1'b0;
    fft_src_ready = 1'b0;
    fft_src_eop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", allOutputs(), 128'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Two full N=8 frames back to back: exactly one idle bubble between EOP and next SOP.
    applyStimulus(8, 8, 1'b1);
    applyStimulus(8, 8, 1'b1);
    exp_inflight += 2;
    waitDrain();
    checkOutput("bubble", 128'(sop_gap), 128'(2));
    checkOutput("frame_count", 128'(frame_count), 128'(exp_frames));
    srcEop();
    srcEop();

    // Short N=16 frame: zero padding with upstream held off.
    applyStimulus(16, 6, 1'b1);
    exp_inflight++;
    pad_ready = 0;
    for (int b = 0; b < 500 && exp_q.size() != 0; b++) begin
      @(negedge clk);
      if (in_ready) pad_ready++;
    end
    checkOutput("pad_in_ready", 128'(pad_ready), 128'(0));
    waitDrain();
    srcEop();

    // Illegal size blocks the frame until a legal one is presented.
    cfg_points = 8'd100;
    in_valid = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (in_ready) bad++;
      @(posedge clk);
      #1;
    end
    checkOutput("cfg_idle_ready", 128'(bad), 128'(0));
    checkOutput("cfg_err", 128'(cfg_err), 128'(1));
    in_valid = 1'b0;
    runFrame(32, 32, 1'b0);

    // Random sizes, lengths and sink stalls.
    stall_mode = 1'b1;
    for (int f = 0; f < 20; f++) begin
      n = 8 << $urandom_range(0, 4);
      use_last = 1'($urandom_range(0, 1));
      len = use_last ? int'($urandom_range(1, n)) : n;
      runFrame(n, len, use_last);
    end
    stall_mode = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("frame_count_rand", 128'(frame_count), 128'(exp_frames));

    // In-flight cap: third frame waits for a source EOP.
    base = sop_count;
    applyStimulus(8, 8, 1'b0);
    applyStimulus(16, 16, 1'b0);
    exp_inflight += 2;
    waitDrain();
    fork
      applyStimulus(8, 8, 1'b0);
      begin
        repeat (40) @(posedge clk);
        #2;
        checkOutput("inflight_block", 128'(sop_count), 128'(base + MAXI));
        srcEop();
      end
    join
    exp_inflight++;
    waitDrain();
    checkOutput("inflight_resume", 128'(sop_count), 128'(base + 3));
    srcEop();
    srcEop();
    checkOutput("proto_clean", 128'(proto_err), 128'(exp_proto));

    // Source EOP with nothing in flight.
    srcEop();
    @(negedge clk);
    checkOutput("proto_err", 128'(proto_err), 128'(exp_proto));
    @(posedge clk);
    #1;

    // Reset in the middle of an N=8 frame, then a clean frame.
    cfg_points = 8'd8;
    for (int i = 0; i < 3; i++) begin
      mon_e.re  = DW'($urandom);
      mon_e.im  = DW'($urandom);
      mon_e.sop = (i == 0);
      mon_e.eop = 1'b0;
      mon_e.pts = 8'd8;
      exp_q.push_back(mon_e);
      sendSample(mon_e.re, mon_e.im, 1'b0, ok);
    end
    in_real = DW'($urandom);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_reset", allOutputs(), 128'(0));
    exp_q.delete();
    exp_inflight = 0;
    exp_proto = 1'b0;
    exp_frames = 0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base = sop_count;
    runFrame(8, 8, 1'b1);
    checkOutput("post_reset_fc", 128'(frame_count), 128'(exp_frames));
    checkOutput("post_reset_sop", 128'(sop_count), 128'(base + 1));
    checkOutput("post_reset_err", 128'({cfg_err, proto_err}), 128'({1'b0, exp_proto}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
